// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains 16-bit words from a normal-mode FIFO, sends each as two UART bytes, high first.
// Define UART_PARITY_EN for 8E1 framing; the default build is 8N1.
module fifo_uart_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic        clock,
  input  logic        rstn,
  input  logic        enable,
  input  logic [15:0] fifo_data_in,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic        tx,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam int unsigned CPB = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

  if (CPB < 2) begin : g_bad_baud
    $error("fifo_uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          byte_q, byte_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   sent_q, sent_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    cur_byte;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= 1'b0;
      word_q  <= '0;
      sent_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      sent_q  <= sent_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    sent_d  = sent_q;
    tick    = (cnt_q == CNT_MAX);
    cnt_inc = tick ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_POP;
      end
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        word_d  = fifo_data_in;
        byte_d  = 1'b0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_inc;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = cnt_inc;
        if (tick) begin
          bit_d = bit_q + 3'd1;
`ifdef UART_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_inc;
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        cnt_d = cnt_inc;
        if (tick) begin
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = S_START;
          end else begin
            sent_d  = sent_q + 16'd1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is registered from next-state values so it changes on the same edge as the FSM
  always_comb begin
    cur_byte = byte_d ? word_d[7:0] : word_d[15:8];
    tx_d     = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_d];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d     = (state_d != S_IDLE);
    fifo_rdreq = rstn && (state_q == S_IDLE) && enable && !fifo_empty;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign words_sent = sent_q;

endmodule
